term_writer: RTL and testbench

- Text-terminal write stage upstream of the VGA pixel controller.
- Accepts a byte stream (keyboard/UART) over a valid/ready handshake, tracks the cursor and interprets control codes.
- Issues writes into the 80x30 character VRAM that the pixel controller reads, so that VRAM gets a real write port.
- Line-wrap and clear sweeps run as multi-cycle states; input is back-pressured during them.

---
 rtl/term_pkg.sv | 18 +
 rtl/cell_addr.sv | 16 +
 rtl/term_writer.sv | 164 ++++++++++++++++
 tb/tb_term_writer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared constants for the text-terminal write path (also used by the pixel side).
package term_pkg;
  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int VRAM_AW = 12;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_SCR  = 2'd2
  } state_e;
endpackage

// File: rtl/cell_addr.sv
// Character cell address = row*80 + col, built from shifts so the pixel side maps identically.
module cell_addr
  import term_pkg::*;
(
  input  logic [4:0]         row_i,
  input  logic [6:0]         col_i,
  output logic [VRAM_AW-1:0] addr_o
);
  logic [VRAM_AW-1:0] row_w;
  logic [VRAM_AW-1:0] col_w;

  assign row_w  = {{(VRAM_AW-5){1'b0}}, row_i};
  assign col_w  = {{(VRAM_AW-7){1'b0}}, col_i};
  // 80 = 64 + 16; max result 2399 fits in 12 bits
  assign addr_o = (row_w << 6) + (row_w << 4) + col_w;
endmodule

// File: rtl/term_writer.sv
// Terminal write stage: takes a byte stream, tracks the cursor, writes character VRAM
// and runs line/screen clear sweeps while holding off the input.
module term_writer #(
  parameter int         COLS           = term_pkg::COLS,
  parameter int         ROWS           = term_pkg::ROWS,
  parameter logic [7:0] BLANK          = term_pkg::BLANK,
  parameter int         CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        vram_we,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);
  import term_pkg::*;

  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [11:0] LINE_SPAN = 12'(COLS - 1);
  localparam logic [11:0] SCR_LAST  = 12'(ROWS * COLS - 1);

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        start_q, start_d;
  logic [11:0] clr_addr_q, clr_addr_d;
  logic [11:0] clr_end_q, clr_end_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [4:0]  bs_row, wr_row, nl_row;
  logic [6:0]  bs_col, wr_col;
  logic [11:0] wr_addr, line_addr;
  logic        is_print, is_bs;

  assign is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign is_bs    = (char_data == BS);
  assign nl_row   = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  // Backspace target: previous column, or end of the previous row
  always_comb begin
    bs_row = row_q;
    bs_col = col_q;
    if (col_q != 7'd0) begin
      bs_col = col_q - 7'd1;
    end else if (row_q != 5'd0) begin
      bs_row = row_q - 5'd1;
      bs_col = LAST_COL;
    end
  end

  assign wr_row = is_bs ? bs_row : row_q;
  assign wr_col = is_bs ? bs_col : col_q;

  cell_addr u_wr_addr   (.row_i(wr_row), .col_i(wr_col), .addr_o(wr_addr));
  cell_addr u_line_addr (.row_i(nl_row), .col_i(7'd0),   .addr_o(line_addr));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    start_d    = start_q;
    clr_addr_d = clr_addr_q;
    clr_end_d  = clr_end_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          // Power-on clear holds the input off for one cycle before the sweep
          start_d    = 1'b0;
          state_d    = CLR_SCR;
          clr_addr_d = 12'd0;
          clr_end_d  = SCR_LAST;
        end else if (char_valid) begin
          if (is_print) begin
            we_d    = 1'b1;
            addr_d  = wr_addr;
            wdata_d = char_data;
            if (col_q == LAST_COL) begin
              row_d      = nl_row;
              col_d      = 7'd0;
              state_d    = CLR_LINE;
              clr_addr_d = line_addr;
              clr_end_d  = line_addr + LINE_SPAN;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (char_data == CR) begin
            col_d = 7'd0;
          end else if (char_data == LF) begin
            row_d      = nl_row;
            col_d      = 7'd0;
            state_d    = CLR_LINE;
            clr_addr_d = line_addr;
            clr_end_d  = line_addr + LINE_SPAN;
          end else if (is_bs) begin
            if ((row_q != 5'd0) || (col_q != 7'd0)) begin
              row_d   = bs_row;
              col_d   = bs_col;
              we_d    = 1'b1;
              addr_d  = wr_addr;
              wdata_d = BLANK;
            end
          end else if (char_data == FF) begin
            row_d      = 5'd0;
            col_d      = 7'd0;
            state_d    = CLR_SCR;
            clr_addr_d = 12'd0;
            clr_end_d  = SCR_LAST;
          end
        end
      end
      CLR_LINE, CLR_SCR: begin
        we_d    = 1'b1;
        addr_d  = clr_addr_q;
        wdata_d = BLANK;
        if (clr_addr_q == clr_end_q) state_d = IDLE;
        else clr_addr_d = clr_addr_q + 12'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= (CLEAR_ON_RESET != 0);
      row_q      <= 5'd0;
      col_q      <= 7'd0;
      clr_addr_q <= 12'd0;
      clr_end_q  <= 12'd0;
      we_q       <= 1'b0;
      addr_q     <= 12'd0;
      wdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      row_q      <= row_d;
      col_q      <= col_d;
      clr_addr_q <= clr_addr_d;
      clr_end_q  <= clr_end_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign char_ready = (state_q == IDLE) && !start_q;
  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: reset sweep, printing, wraps, control codes, reset abort.
module tb_term_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  term_writer dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check({tag, ".row"}, 32'(cursor_row), 32'(r));
    check({tag, ".col"}, 32'(cursor_col), 32'(c));
  endtask

  // Drive one byte at a negedge; returns at the next negedge with its result visible
  task automatic send(input logic [7:0] d);
    char_data  = d;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_we(input string tag, input int bound);
    int k = 0;
    while (!vram_we && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(vram_we), 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int k = 0;
    while (!char_ready && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(char_ready), 32'd1);
  endtask

  // n consecutive BLANK writes from base; ready drops back only alongside the final write
  task automatic sweep(input string tag, input int base, input int n, input bit ends);
    for (int i = 0; i < n; i++) begin
      logic rdy_exp;
      logic ok;
      rdy_exp = ends && (i == n - 1);
      ok = vram_we && (32'(vram_addr) == 32'(base + i)) && (vram_wdata == 8'h20)
           && (char_ready == rdy_exp) && (busy == !rdy_exp);
      check($sformatf("%s[%0d]", tag, i), 32'(ok), 32'd1);
      if (i != n - 1) @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst.we", 32'(vram_we), 32'd0);
    check("rst.addr", 32'(vram_addr), 32'd0);
    check("rst.wdata", 32'(vram_wdata), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check_cursor("rst", 0, 0);

    // Power-on clear sweep
    rst = 1'b0;
    @(negedge clk);
    check("por.ready_low", 32'(char_ready), 32'd0);
    wait_we("por.start", 5);
    sweep("por", 0, 2400, 1'b1);
    @(negedge clk);
    check("por.we_after", 32'(vram_we), 32'd0);
    check("por.ready", 32'(char_ready), 32'd1);
    check_cursor("por", 0, 0);

    // "A","B" back to back
    send(8'h41);
    check("A.we", 32'(vram_we), 32'd1);
    check("A.addr", 32'(vram_addr), 32'd0);
    check("A.data", 32'(vram_wdata), 32'h41);
    check("A.ready", 32'(char_ready), 32'd1);
    check_cursor("A", 0, 1);
    send(8'h42);
    check("B.we", 32'(vram_we), 32'd1);
    check("B.addr", 32'(vram_addr), 32'd1);
    check("B.data", 32'(vram_wdata), 32'h42);
    check_cursor("B", 0, 2);
    @(negedge clk);
    check("B.one_cycle", 32'(vram_we), 32'd0);

    // Fill to column 79, then print at the last column
    for (int i = 0; i < 77; i++) send(8'h2E);
    check_cursor("col79", 0, 79);
    send(8'h5A);
    check("Z.we", 32'(vram_we), 32'd1);
    check("Z.addr", 32'(vram_addr), 32'd79);
    check("Z.data", 32'(vram_wdata), 32'h5A);
    check("Z.ready", 32'(char_ready), 32'd0);
    check_cursor("Z", 1, 0);
    @(negedge clk);
    sweep("wrap", 80, 80, 1'b1);
    @(negedge clk);
    check("wrap.we_after", 32'(vram_we), 32'd0);

    // Walk to (29,5) and LF to wrap to the top row
    for (int i = 0; i < 28; i++) begin
      send(8'h0A);
      wait_ready("lf.walk", 200);
    end
    for (int i = 0; i < 5; i++) send(8'h2E);
    check_cursor("at29_5", 29, 5);
    send(8'h0A);
    check("lf.no_write", 32'(vram_we), 32'd0);
    check("lf.busy", 32'(busy), 32'd1);
    check_cursor("lf", 0, 0);
    @(negedge clk);
    sweep("lf", 0, 80, 1'b1);
    @(negedge clk);

    // Backspace across a row boundary: (3,0) -> (2,79) = 2*80+79
    for (int i = 0; i < 3; i++) begin
      send(8'h0A);
      wait_ready("bs.walk", 200);
    end
    check_cursor("at3_0", 3, 0);
    send(8'h08);
    check("bs.we", 32'(vram_we), 32'd1);
    check("bs.addr", 32'(vram_addr), 32'd239);
    check("bs.data", 32'(vram_wdata), 32'h20);
    check_cursor("bs", 2, 79);

    // CR at (4,17)
    send(8'h0D);
    for (int i = 0; i < 2; i++) begin
      send(8'h0A);
      wait_ready("cr.walk", 200);
    end
    for (int i = 0; i < 17; i++) send(8'h2E);
    check_cursor("at4_17", 4, 17);
    send(8'h0D);
    check("cr.no_write", 32'(vram_we), 32'd0);
    check_cursor("cr", 4, 0);

    // Form feed, aborted by reset after 100 writes
    send(8'h0C);
    check("ff.busy", 32'(busy), 32'd1);
    check("ff.no_write", 32'(vram_we), 32'd0);
    check_cursor("ff", 0, 0);
    wait_we("ff.start", 5);
    sweep("ff", 0, 100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort.we", 32'(vram_we), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check_cursor("abort", 0, 0);
    rst = 1'b0;
    wait_we("resweep.start", 5);
    sweep("resweep", 0, 2400, 1'b1);
    @(negedge clk);

    // BS at home is a no-op; BEL is swallowed
    send(8'h08);
    check("bs0.no_write", 32'(vram_we), 32'd0);
    check_cursor("bs0", 0, 0);
    check("bel.ready", 32'(char_ready), 32'd1);
    send(8'h07);
    check("bel.no_write", 32'(vram_we), 32'd0);
    check("bel.ready_after", 32'(char_ready), 32'd1);
    check_cursor("bel", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
